// File: rtl/elink_uplink_frame_tx.sv
// elink_uplink_frame_tx
// Serialises 76-bit uplink words onto a 2-bit e-link, one dibit per clock.
// Each frame is a SOF byte, 38 payload dibits, a CRC-8 byte and an EOF byte,
// all sent MSB first, followed by a minimum idle gap before the next SOF.
// A single holding register sits in front of the payload shift register, so
// one word can wait while another frame is on the line.

module elink_uplink_frame_tx #(
  parameter int unsigned IFG_DIBITS = 4,
  parameter logic [7:0]  SOF_BYTE   = 8'h3C,
  parameter logic [7:0]  EOF_BYTE   = 8'hDC,
  parameter logic [1:0]  IDLE_DIBIT = 2'b10,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [75:0]      data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [1:0]       tx_elink2bit,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned GAP_W     = $clog2(IFG_DIBITS + 1);
  localparam logic [5:0]  LAST_BYTE = 6'd3;
  localparam logic [5:0]  LAST_PAY  = 6'd37;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PAY,
    ST_CRC,
    ST_EOF
  } state_t;

  state_t           state;
  logic [5:0]       idx;
  logic             hold_vld;
  logic [75:0]      hold_data;
  logic [75:0]      shift;
  logic [7:0]       crc;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  logic             accept;
  logic             start;

  // Selects dibit i (0 = most significant) of a framing byte.
  function automatic logic [1:0] byte_dibit(input logic [7:0] b, input logic [1:0] i);
    case (i)
      2'd0:    return b[7:6];
      2'd1:    return b[5:4];
      2'd2:    return b[3:2];
      default: return b[1:0];
    endcase
  endfunction

  // CRC-8, polynomial 0x07, advanced by two message bits, high bit first.
  function automatic logic [7:0] crc8_dibit(input logic [7:0] c, input logic [1:0] d);
    logic [7:0] r;
    r = c;
    for (int b = 1; b >= 0; b--) begin
      r = {r[6:0], 1'b0} ^ ((r[7] ^ d[b]) ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // The gap counter steps down in the same cycle the start decision is made,
  // so the next frame may launch on the cycle the count reaches zero; this
  // leaves exactly IFG_DIBITS idle dibits between EOF and SOF.
  assign gap_next      = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
  assign data_in_ready = ~hold_vld;
  assign accept        = data_in_valid & data_in_ready;
  assign start         = (state == ST_IDLE) && hold_vld && enable && (gap_next == '0);

  // Holding register: filled on a handshake, emptied when its word launches.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      hold_vld  <= 1'b0;
      // NOTE: the data word is cleared too, so a reset leaves no stale payload
      // that could be relaunched; the valid flag alone would suffice functionally.
      hold_data <= '0;
    end else begin
      if (accept) begin
        hold_vld  <= 1'b1;
        hold_data <= data_in;
      end else if (start) begin
        hold_vld  <= 1'b0;
      end
    end
  end

  // Framing FSM: every output is registered from the current state and index,
  // so the line shows a state's dibit one cycle after the state is entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      shift        <= '0;
      crc          <= '0;
      gap_cnt      <= '0;
      tx_elink2bit <= IDLE_DIBIT;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_elink2bit <= IDLE_DIBIT;
          busy         <= 1'b0;
          gap_cnt      <= gap_next;
          if (start) begin
            shift <= hold_data;
            crc   <= 8'h00;
            idx   <= '0;
            state <= ST_SOF;
          end
        end

        ST_SOF: begin
          tx_elink2bit <= byte_dibit(SOF_BYTE, idx[1:0]);
          busy         <= 1'b1;
          if (idx == LAST_BYTE) begin
            idx   <= '0;
            state <= ST_PAY;
          end else begin
            idx <= idx + 6'd1;
          end
        end

        ST_PAY: begin
          tx_elink2bit <= shift[75:74];
          busy         <= 1'b1;
          shift        <= {shift[73:0], 2'b00};
          crc          <= crc8_dibit(crc, shift[75:74]);
          if (idx == LAST_PAY) begin
            idx   <= '0;
            state <= ST_CRC;
          end else begin
            idx <= idx + 6'd1;
          end
        end

        ST_CRC: begin
          // The CRC is consumed by shifting; it is re-zeroed at the next launch.
          tx_elink2bit <= crc[7:6];
          busy         <= 1'b1;
          crc          <= {crc[5:0], 2'b00};
          if (idx == LAST_BYTE) begin
            idx   <= '0;
            state <= ST_EOF;
          end else begin
            idx <= idx + 6'd1;
          end
        end

        ST_EOF: begin
          tx_elink2bit <= byte_dibit(EOF_BYTE, idx[1:0]);
          busy         <= 1'b1;
          if (idx == LAST_BYTE) begin
            idx        <= '0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + CNT_W'(1);
            gap_cnt    <= GAP_W'(IFG_DIBITS);
            state      <= ST_IDLE;
          end else begin
            idx <= idx + 6'd1;
          end
        end

        default: begin
          tx_elink2bit <= IDLE_DIBIT;
          busy         <= 1'b0;
          idx          <= '0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elink_uplink_frame_tx.sv
// Testbench for elink_uplink_frame_tx.
// Accepted words go into a scoreboard queue; a line monitor reassembles each
// 50-dibit frame and compares it with a frame built from the word, using a
// polynomial-division CRC reference.

module tb_elink_uplink_frame_tx;

  localparam logic [7:0] SOF = 8'h3C;
  localparam logic [7:0] EOF = 8'hDC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [75:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [1:0]  tx_elink2bit;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  elink_uplink_frame_tx dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .tx_elink2bit  (tx_elink2bit),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [75:0] exp_q[$];
  int          sof_q[$];
  int          nib = 0;
  int          frames_done = 0;
  int          done_pulses = 0;
  logic [99:0] cur = '0;
  logic [99:0] last_frame = '0;
  logic [15:0] model_cnt = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference CRC: remainder of message * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [75:0] w);
    logic [83:0] r;
    r = {w, 8'h00};
    for (int i = 83; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [99:0] ref_frame(input logic [75:0] w);
    return {SOF, w, ref_crc(w), EOF};
  endfunction

  function automatic logic [75:0] rand_word();
    return {12'($urandom), $urandom, $urandom};
  endfunction

  // Cycle counter, used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: collects frames while busy and checks them against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      nib       = 0;
      cur       = '0;
      model_cnt = '0;
    end else if (busy) begin
      if (nib == 0) sof_q.push_back(cyc);
      cur = {cur[97:0], tx_elink2bit};
      if (frame_done) done_pulses++;
      check("frame_done_pos", 128'(frame_done), 128'(nib == 49));
      nib++;
      if (nib == 50) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 128'(cur), 128'(0));
        end else begin
          check("frame", 128'(cur), 128'(ref_frame(exp_q.pop_front())));
        end
        model_cnt = model_cnt + 16'd1;
        check("frame_cnt", 128'(frame_cnt), 128'(model_cnt));
        last_frame = cur;
        frames_done++;
        nib = 0;
      end
    end else begin
      if (nib != 0) check("short_frame", 128'(nib), 128'(50));
      nib = 0;
      check("idle_tx", 128'(tx_elink2bit), 128'(2'b10));
      check("idle_done", 128'(frame_done), 128'(0));
    end
  end

  bit rand_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) enable = ($urandom_range(0, 3) != 0);
  endtask

  // Offers one word and waits for the handshake; returns the acceptance edge.
  task automatic send(input logic [75:0] w, output int acc);
    bit done;
    int budget;
    done   = 1'b0;
    budget = 0;
    acc    = -1;
    data_in       = w;
    data_in_valid = 1'b1;
    while (!done && budget < 400) begin
      done = data_in_ready && rst;
      tick();
      budget++;
    end
    if (done) begin
      exp_q.push_back(w);
      acc = cyc;
    end else begin
      check("send_timeout", 128'(0), 128'(1));
    end
    data_in_valid = 1'b0;
    data_in       = rand_word();
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 3000) begin
      tick();
      budget++;
    end
    if (budget >= 3000) check("drain_timeout", 128'(0), 128'(1));
    repeat (2) tick();
  endtask

  task automatic wait_nib(input int n);
    int budget;
    budget = 0;
    while (nib < n && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) check("wait_nib_timeout", 128'(nib), 128'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n0;
    int f0;
    int en_cyc;
    logic [75:0] w;

    // 1: reset with valid asserted
    data_in       = rand_word();
    data_in_valid = 1'b1;
    rst           = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_tx", 128'(tx_elink2bit), 128'(2'b10));
      check("rst_ready", 128'(data_in_ready), 128'(1));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_cnt", 128'(frame_cnt), 128'(0));
    end
    rst           = 1'b1;
    data_in_valid = 1'b0;
    repeat (3) tick();

    // 2: single all-zero frame, launch latency
    send(76'h0, acc);
    wait_idle();
    check("t2_latency", 128'(sof_q[$] - acc), 128'(2));
    check("t2_frame", 128'(last_frame), {28'h0, SOF, 76'h0, 8'h00, EOF});
    check("t2_cnt", 128'(frame_cnt), 128'(1));
    check("t2_done_pulses", 128'(done_pulses), 128'(frames_done));

    // 3: three words offered back to back
    n0 = sof_q.size();
    f0 = frames_done;
    send(rand_word(), acc);
    check("t3_ready_low", 128'(data_in_ready), 128'(0));
    send(rand_word(), acc);
    send(rand_word(), acc);
    wait_idle();
    check("t3_frames", 128'(frames_done - f0), 128'(3));
    check("t3_spacing1", 128'(sof_q[n0 + 1] - sof_q[n0]), 128'(54));
    check("t3_spacing2", 128'(sof_q[n0 + 2] - sof_q[n0 + 1]), 128'(54));
    check("t3_cnt", 128'(frame_cnt), 128'(4));

    // 4: only bit 75 set
    w = '0;
    w[75] = 1'b1;
    send(w, acc);
    wait_idle();
    check("t4_first_pay", 128'(last_frame[91:90]), 128'(2'b10));
    check("t4_crc", 128'(last_frame[15:8]), 128'(ref_crc(w)));

    // 5: enable dropped mid-payload holds the queued word
    f0 = frames_done;
    send(rand_word(), acc);
    wait_nib(14);
    enable = 1'b0;
    send(rand_word(), acc);
    repeat (80) tick();
    check("t5_first_done", 128'(frames_done - f0), 128'(1));
    check("t5_held_busy", 128'(busy), 128'(0));
    check("t5_held_ready", 128'(data_in_ready), 128'(0));
    check("t5_held_queue", 128'(exp_q.size()), 128'(1));
    enable = 1'b1;
    en_cyc = cyc;
    wait_idle();
    check("t5_restart", 128'(sof_q[$] - en_cyc), 128'(2));
    check("t5_frames", 128'(frames_done - f0), 128'(2));

    // 6: reset in the middle of the payload
    send(rand_word(), acc);
    wait_nib(24);
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("t6_tx", 128'(tx_elink2bit), 128'(2'b10));
    check("t6_busy", 128'(busy), 128'(0));
    check("t6_cnt", 128'(frame_cnt), 128'(0));
    check("t6_ready", 128'(data_in_ready), 128'(1));
    rst = 1'b1;
    tick();
    f0 = frames_done;
    send(rand_word(), acc);
    wait_idle();
    check("t6_after", 128'(frames_done - f0), 128'(1));
    check("t6_cnt_after", 128'(frame_cnt), 128'(1));

    // 7: random words, gaps and enable toggling
    f0 = frames_done;
    rand_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 60)) tick();
      send(rand_word(), acc);
    end
    rand_en = 1'b0;
    enable  = 1'b1;
    wait_idle();
    check("t7_frames", 128'(frames_done - f0), 128'(25));
    check("t7_done_pulses", 128'(done_pulses), 128'(frames_done));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
